memacc: RTL and testbench

MEMACC -- requirements
Module: memacc

---
 rtl/memacc.sv | 189 ++++++++++++++++++
 tb/tb_memacc.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memacc.sv
// Memory-access pipeline stage: forwards EX results to WB and runs one 32-bit data-bus
// transaction per load/store. Define MEMACC_ALIGN_CHECK_EN to trap misaligned accesses.
`ifndef W_OPER
`define W_OPER 4
`endif
`ifndef W_REGF
`define W_REGF 5
`endif
`ifndef W_DATA
`define W_DATA 32
`endif
`ifndef W_ADDR
`define W_ADDR 32
`endif

module memacc (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [`W_OPER-1:0]  in_oper,
    input  logic [`W_REGF-1:0]  in_regf,
    input  logic [`W_DATA-1:0]  in_data_a,
    input  logic [`W_DATA-1:0]  in_data_b,
    input  logic [`W_ADDR-1:0]  in_pc,
    input  logic                mem_en,
    input  logic                mem_we,
    input  logic [1:0]          mem_size,
    input  logic                mem_sext,
    input  logic                flush,
    output logic                dbus_req,
    output logic                dbus_we,
    output logic [3:0]          dbus_be,
    output logic [`W_ADDR-1:0]  dbus_addr,
    output logic [`W_DATA-1:0]  dbus_wdata,
    input  logic                dbus_ack,
    input  logic [`W_DATA-1:0]  dbus_rdata,
    output logic                out_valid,
    output logic [`W_OPER-1:0]  out_oper,
    output logic [`W_REGF-1:0]  out_regf,
    output logic [`W_ADDR-1:0]  out_pc,
    output logic [`W_DATA-1:0]  out_data_a,
    output logic [`W_DATA-1:0]  out_data_b,
    output logic                exc_adel,
    output logic                exc_ades
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]         state_reg;
    logic [`W_OPER-1:0] hold_oper_reg;
    logic [`W_REGF-1:0] hold_regf_reg;
    logic [`W_DATA-1:0] hold_a_reg;
    logic [`W_DATA-1:0] hold_b_reg;
    logic [`W_ADDR-1:0] hold_pc_reg;
    logic               hold_we_reg;
    logic [1:0]         hold_size_reg;
    logic               hold_sext_reg;
    logic               kill_reg;

    logic               in_wait;
    logic               accept;
    logic               misalign;
    logic               go_bus;
    logic [3:0]         be_word;
    logic [7:0]         rd_lane [4];
    logic [7:0]         load_byte;
    logic [15:0]        load_half;
    logic [`W_DATA-1:0] load_data;

    assign in_wait  = (state_reg == WAIT);
    assign in_ready = (state_reg == IDLE);
    assign accept   = in_valid && !flush;

`ifdef MEMACC_ALIGN_CHECK_EN
    assign misalign = mem_en && (((mem_size == 2'd1) && in_data_a[0]) ||
                                 (mem_size[1] && (in_data_a[1:0] != 2'b00)));
`else
    // Low address bits are simply ignored by the lane logic below.
    assign misalign = 1'b0;
`endif

    assign go_bus = accept && mem_en && !misalign;

    // Bus outputs come only from holding registers, so they stay still for the whole WAIT.
    always_comb begin
        be_word = 4'b1111;
        case (hold_size_reg)
            2'd0:    be_word = 4'b0001 << hold_a_reg[1:0];
            2'd1:    be_word = 4'b0011 << {hold_a_reg[1], 1'b0};
            default: be_word = 4'b1111;
        endcase
    end

    assign dbus_req  = in_wait;
    assign dbus_we   = in_wait && hold_we_reg;
    assign dbus_be   = in_wait ? be_word : 4'b0000;
    assign dbus_addr = in_wait ? {hold_a_reg[31:2], 2'b00} : '0;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign dbus_wdata[8*gi +: 8] = !in_wait               ? 8'h00 :
                                           (hold_size_reg == 2'd0) ? hold_b_reg[7:0] :
                                           (hold_size_reg == 2'd1) ? hold_b_reg[8*(gi%2) +: 8] :
                                                                     hold_b_reg[8*gi +: 8];
            assign rd_lane[gi] = dbus_rdata[8*gi +: 8];
        end
    endgenerate

    assign load_byte = rd_lane[hold_a_reg[1:0]];
    assign load_half = hold_a_reg[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];

    always_comb begin
        load_data = dbus_rdata;
        case (hold_size_reg)
            2'd0:    load_data = {{24{hold_sext_reg && load_byte[7]}}, load_byte};
            2'd1:    load_data = {{16{hold_sext_reg && load_half[15]}}, load_half};
            default: load_data = dbus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            hold_oper_reg <= '0;
            hold_regf_reg <= '0;
            hold_a_reg    <= '0;
            hold_b_reg    <= '0;
            hold_pc_reg   <= '0;
            hold_we_reg   <= 1'b0;
            hold_size_reg <= 2'd0;
            hold_sext_reg <= 1'b0;
            kill_reg      <= 1'b0;
            out_valid     <= 1'b0;
            out_oper      <= '0;
            out_regf      <= '0;
            out_pc        <= '0;
            out_data_a    <= '0;
            out_data_b    <= '0;
            exc_adel      <= 1'b0;
            exc_ades      <= 1'b0;
        end else if (state_reg == IDLE) begin
            exc_adel <= 1'b0;
            exc_ades <= 1'b0;
            if (go_bus) begin
                state_reg     <= WAIT;
                hold_oper_reg <= in_oper;
                hold_regf_reg <= in_regf;
                hold_a_reg    <= in_data_a;
                hold_b_reg    <= in_data_b;
                hold_pc_reg   <= in_pc;
                hold_we_reg   <= mem_we;
                hold_size_reg <= mem_size;
                hold_sext_reg <= mem_sext;
                kill_reg      <= 1'b0;
                out_valid     <= 1'b0;
            end else if (accept) begin
                out_valid  <= 1'b1;
                out_oper   <= in_oper;
                out_regf   <= in_regf;
                out_pc     <= in_pc;
                out_data_a <= in_data_a;
                out_data_b <= '0;
                exc_adel   <= misalign && !mem_we;
                exc_ades   <= misalign && mem_we;
            end else begin
                out_valid <= 1'b0;
            end
        end else begin
            // A flush anywhere in WAIT only poisons the result; the bus cycle still completes.
            if (dbus_ack) begin
                state_reg  <= IDLE;
                out_valid  <= !(kill_reg || flush);
                out_oper   <= hold_oper_reg;
                out_regf   <= hold_regf_reg;
                out_pc     <= hold_pc_reg;
                out_data_a <= hold_a_reg;
                out_data_b <= hold_we_reg ? '0 : load_data;
            end else begin
                out_valid <= 1'b0;
                if (flush) begin
                    kill_reg <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_memacc.sv
// Directed-vector bench for memacc; expectations are hand-computed per vector.
`ifndef W_OPER
`define W_OPER 4
`endif
`ifndef W_REGF
`define W_REGF 5
`endif
`ifndef W_DATA
`define W_DATA 32
`endif
`ifndef W_ADDR
`define W_ADDR 32
`endif

module tb_memacc;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [`W_OPER-1:0] in_oper;
    logic [`W_REGF-1:0] in_regf;
    logic [`W_DATA-1:0] in_data_a;
    logic [`W_DATA-1:0] in_data_b;
    logic [`W_ADDR-1:0] in_pc;
    logic               mem_en;
    logic               mem_we;
    logic [1:0]         mem_size;
    logic               mem_sext;
    logic               flush;
    logic               dbus_req;
    logic               dbus_we;
    logic [3:0]         dbus_be;
    logic [`W_ADDR-1:0] dbus_addr;
    logic [`W_DATA-1:0] dbus_wdata;
    logic               dbus_ack;
    logic [`W_DATA-1:0] dbus_rdata;
    logic               out_valid;
    logic [`W_OPER-1:0] out_oper;
    logic [`W_REGF-1:0] out_regf;
    logic [`W_ADDR-1:0] out_pc;
    logic [`W_DATA-1:0] out_data_a;
    logic [`W_DATA-1:0] out_data_b;
    logic               exc_adel;
    logic               exc_ades;

    int n_checks = 0;
    int n_fail   = 0;

    memacc dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_oper    (in_oper),
        .in_regf    (in_regf),
        .in_data_a  (in_data_a),
        .in_data_b  (in_data_b),
        .in_pc      (in_pc),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_size   (mem_size),
        .mem_sext   (mem_sext),
        .flush      (flush),
        .dbus_req   (dbus_req),
        .dbus_we    (dbus_we),
        .dbus_be    (dbus_be),
        .dbus_addr  (dbus_addr),
        .dbus_wdata (dbus_wdata),
        .dbus_ack   (dbus_ack),
        .dbus_rdata (dbus_rdata),
        .out_valid  (out_valid),
        .out_oper   (out_oper),
        .out_regf   (out_regf),
        .out_pc     (out_pc),
        .out_data_a (out_data_a),
        .out_data_b (out_data_b),
        .exc_adel   (exc_adel),
        .exc_ades   (exc_ades)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        flush    = 1'b0;
        dbus_ack = 1'b0;
    endtask

    task automatic present(input logic en, input logic we, input logic [1:0] sz,
                           input logic sx, input logic [31:0] a, input logic [31:0] b);
        in_valid  = 1'b1;
        mem_en    = en;
        mem_we    = we;
        mem_size  = sz;
        mem_sext  = sx;
        in_data_a = a;
        in_data_b = b;
        in_oper   = 4'h3;
        in_regf   = 5'd9;
        in_pc     = 32'h0000_0400;
    endtask

    // Full bus transaction: issue, hold for 'delay' WAIT cycles, then ack.
    task automatic mem_op(input string tag, input logic we, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] rdata,
                          input int delay, input logic [3:0] exp_be, input logic [31:0] exp_addr,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_db);
        present(1'b1, we, sz, sx, a, b);
        tick();
        idle_in();
        check({tag, "_req"}, 32'(dbus_req), 32'd1);
        check({tag, "_we"}, 32'(dbus_we), 32'(we));
        check({tag, "_be"}, 32'(dbus_be), 32'(exp_be));
        check({tag, "_addr"}, dbus_addr, exp_addr);
        check({tag, "_wdata"}, dbus_wdata, exp_wdata);
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < delay; i++) begin
            tick();
            check({tag, "_req_hold"}, 32'(dbus_req), 32'd1);
            check({tag, "_be_hold"}, 32'(dbus_be), 32'(exp_be));
        end
        dbus_ack   = 1'b1;
        dbus_rdata = rdata;
        tick();
        dbus_ack   = 1'b0;
        dbus_rdata = 32'h0;
        check({tag, "_ovalid"}, 32'(out_valid), 32'd1);
        check({tag, "_data_b"}, out_data_b, exp_db);
        check({tag, "_data_a"}, out_data_a, a);
        check({tag, "_exc"}, {30'd0, exc_adel, exc_ades}, 32'd0);
        check({tag, "_req_done"}, 32'(dbus_req), 32'd0);
        $display("txn %s a=%h b=%h be=%b data_b=%h", tag, a, b, exp_be, out_data_b);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_oper    = '0;
        in_regf    = '0;
        in_data_a  = '0;
        in_data_b  = '0;
        in_pc      = '0;
        mem_size   = 2'd0;
        mem_sext   = 1'b0;
        dbus_rdata = '0;
        idle_in();
        #3;
        check("rst_ovalid", 32'(out_valid), 32'd0);
        check("rst_req", 32'(dbus_req), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_data", out_data_a | out_data_b | out_pc, 32'd0);
        check("rst_exc", {30'd0, exc_adel, exc_ades}, 32'd0);
        #9 rst_n = 1'b1;
        tick();

        // ALU pass-through, no bus activity
        present(1'b0, 1'b0, 2'd0, 1'b0, 32'h55, 32'h0);
        in_pc   = 32'h100;
        in_regf = 5'd7;
        #1;
        check("alu_ready", 32'(in_ready), 32'd1);
        tick();
        idle_in();
        check("alu_ovalid", 32'(out_valid), 32'd1);
        check("alu_data_a", out_data_a, 32'h55);
        check("alu_regf", 32'(out_regf), 32'd7);
        check("alu_pc", out_pc, 32'h100);
        check("alu_oper", 32'(out_oper), 32'd3);
        check("alu_data_b", out_data_b, 32'h0);
        check("alu_req", 32'(dbus_req), 32'd0);
        check("alu_ready2", 32'(in_ready), 32'd1);
        $display("txn alu a=00000055 out_data_a=%h", out_data_a);
        tick();
        check("idle_ovalid", 32'(out_valid), 32'd0);

        mem_op("lb_sext", 1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 32'h80FF_FFFF, 2,
               4'b1000, 32'h1000, 32'h0, 32'hFFFF_FF80);
        mem_op("sh", 1'b1, 2'd1, 1'b0, 32'h2002, 32'h1234_ABCD, 32'hFFFF_FFFF, 0,
               4'b1100, 32'h2000, 32'hABCD_ABCD, 32'h0);
        mem_op("sb", 1'b1, 2'd0, 1'b0, 32'h2001, 32'h0000_005A, 32'h0, 1,
               4'b0010, 32'h2000, 32'h5A5A_5A5A, 32'h0);
        mem_op("lh_sext", 1'b0, 2'd1, 1'b1, 32'h0006, 32'h0, 32'h8001_1234, 1,
               4'b1100, 32'h0004, 32'h0, 32'hFFFF_8001);
        mem_op("lbu", 1'b0, 2'd0, 1'b0, 32'h0005, 32'h0, 32'hFF00_AB00, 0,
               4'b0010, 32'h0004, 32'h0, 32'h0000_00AB);
        mem_op("sw", 1'b1, 2'd2, 1'b0, 32'h0010, 32'hCAFE_F00D, 32'h0, 0,
               4'b1111, 32'h0010, 32'hCAFE_F00D, 32'h0);

        // Flush in IDLE, right after a valid result
        present(1'b1, 1'b0, 2'd2, 1'b0, 32'h5000, 32'h0);
        flush = 1'b1;
        tick();
        idle_in();
        check("flush_idle_ovalid", 32'(out_valid), 32'd0);
        check("flush_idle_req", 32'(dbus_req), 32'd0);
        check("flush_idle_ready", 32'(in_ready), 32'd1);
        $display("txn flush_idle a=00005000");

        // Stray ack in IDLE
        dbus_ack = 1'b1;
        tick();
        dbus_ack = 1'b0;
        check("ack_idle_ovalid", 32'(out_valid), 32'd0);
        check("ack_idle_req", 32'(dbus_req), 32'd0);
        $display("txn ack_idle");

        // Flush one cycle into WAIT, ack two cycles later
        present(1'b1, 1'b0, 2'd2, 1'b0, 32'h4000, 32'h0);
        tick();
        idle_in();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_wait_req", 32'(dbus_req), 32'd1);
        check("flush_wait_ovalid", 32'(out_valid), 32'd0);
        tick();
        check("flush_wait_req2", 32'(dbus_req), 32'd1);
        dbus_ack   = 1'b1;
        dbus_rdata = 32'h1234_5678;
        tick();
        dbus_ack   = 1'b0;
        check("flush_wait_done_ovalid", 32'(out_valid), 32'd0);
        check("flush_wait_done_ready", 32'(in_ready), 32'd1);
        check("flush_wait_done_req", 32'(dbus_req), 32'd0);
        $display("txn flush_wait a=00004000");

        // Ack and flush together
        present(1'b1, 1'b0, 2'd2, 1'b0, 32'h4004, 32'h0);
        tick();
        idle_in();
        dbus_ack = 1'b1;
        flush    = 1'b1;
        tick();
        dbus_ack = 1'b0;
        flush    = 1'b0;
        check("ack_flush_ovalid", 32'(out_valid), 32'd0);
        check("ack_flush_ready", 32'(in_ready), 32'd1);
        $display("txn ack_flush a=00004004");

        // Misaligned word load
`ifdef MEMACC_ALIGN_CHECK_EN
        present(1'b1, 1'b0, 2'd2, 1'b0, 32'h3001, 32'h0);
        #1;
        check("mis_lw_noreq", 32'(dbus_req), 32'd0);
        tick();
        idle_in();
        check("mis_lw_noreq2", 32'(dbus_req), 32'd0);
        check("mis_lw_ovalid", 32'(out_valid), 32'd1);
        check("mis_lw_adel", 32'(exc_adel), 32'd1);
        check("mis_lw_ades", 32'(exc_ades), 32'd0);
        check("mis_lw_data_b", out_data_b, 32'h0);
        $display("txn mis_lw a=00003001 exc_adel=%b", exc_adel);
        present(1'b1, 1'b1, 2'd1, 1'b0, 32'h3003, 32'h0);
        tick();
        idle_in();
        check("mis_sh_ades", 32'(exc_ades), 32'd1);
        check("mis_sh_adel", 32'(exc_adel), 32'd0);
        check("mis_sh_req", 32'(dbus_req), 32'd0);
        tick();
        check("mis_clear", {30'd0, exc_adel, exc_ades}, 32'd0);
        $display("txn mis_sh a=00003003 exc_ades=1");
`else
        mem_op("mis_lw", 1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, 32'hDEAD_BEEF, 0,
               4'b1111, 32'h3000, 32'h0, 32'hDEAD_BEEF);
        mem_op("mis_lh", 1'b0, 2'd1, 1'b0, 32'h3003, 32'h0, 32'hBEEF_0000, 0,
               4'b1100, 32'h3000, 32'h0, 32'h0000_BEEF);
`endif

        // Reset during WAIT abandons the transaction
        present(1'b1, 1'b0, 2'd2, 1'b0, 32'h7000, 32'h0);
        tick();
        idle_in();
        check("rstw_req_before", 32'(dbus_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rstw_req", 32'(dbus_req), 32'd0);
        check("rstw_ovalid", 32'(out_valid), 32'd0);
        check("rstw_ready", 32'(in_ready), 32'd1);
        check("rstw_data_a", out_data_a, 32'h0);
        $display("txn reset_in_wait a=00007000");
        #2 rst_n = 1'b1;
        tick();
        mem_op("post_rst_lb", 1'b0, 2'd0, 1'b0, 32'h0000, 32'h0, 32'h0000_007F, 1,
               4'b0001, 32'h0000, 32'h0, 32'h0000_007F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
